prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the instruction queue entry count; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1 bit, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit, instruction memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits, fetch byte address.
REQ-008 SHALL have port imem_resp_valid, input, 1 bit, response data valid; responses return in request order, no backpressure.
REQ-009 SHALL have port imem_resp_data, input, 32 bits, fetched instruction word.
REQ-010 SHALL have port stall, input, 1 bit, decode stage cannot accept (from hazard logic).
REQ-011 SHALL have port redirect, input, 1 bit, branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc, input, 32 bits, new fetch address, valid when redirect=1.
REQ-013 SHALL have port if_valid, output, 1 bit, if_instruction/if_pc valid to the IF/ID barrier.
REQ-014 SHALL have port if_instruction, output, 32 bits, queue head instruction.
REQ-015 SHALL have port if_pc, output, 32 bits, byte address of queue head instruction.

Function
REQ-016 SHALL hold registers: fetch_pc (32b), queue of DEPTH {pc, instruction} entries with head/tail pointers and count, inflight counter (0..DEPTH), drop counter (0..DEPTH).
REQ-017 SHALL drive imem_req_valid=1 iff reset=0, redirect=0, and count+inflight < DEPTH (credit rule; the queue never overflows).
REQ-018 SHALL drive imem_req_addr=fetch_pc combinationally; imem_req_valid, once raised, is held with the same address until it is accepted or a redirect occurs.
REQ-019 SHALL, on request handshake (imem_req_valid & imem_req_ready), set fetch_pc<=fetch_pc+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0) and increment inflight; handshake and response in the same cycle leave inflight unchanged.
REQ-020 SHALL record the requested pc of each inflight request in order, so the returning word is paired with its address.
REQ-021 SHALL, on imem_resp_valid with drop=0, push {pc, imem_resp_data} at tail and decrement inflight; with drop>0, discard the word and decrement both drop and inflight.
REQ-022 SHALL drive if_valid=1 iff count!=0 and redirect=0; if_instruction/if_pc show the head entry (don't-care when if_valid=0).
REQ-023 SHALL pop the head when if_valid=1 and stall=0; simultaneous push and pop leave count unchanged; a push into an empty queue is visible on if_valid the following cycle (one-cycle response-to-decode latency).
REQ-024 SHALL, on redirect=1 (highest priority over push, pop and request): empty the queue (count<=0, head=tail), set fetch_pc<=redirect_pc, set drop<=inflight minus 1 if imem_resp_valid that cycle, else inflight; the response arriving that cycle is discarded.
REQ-025 SHALL issue the first request to redirect_pc in the cycle after redirect, subject to REQ-017.
REQ-026 SHALL ignore stall while count=0; stall SHALL NOT block requests or responses.
REQ-027 SHALL treat redirect_pc bits [1:0] as given; alignment checks are outside this block.

Reset
REQ-028 SHALL, while reset=1, force fetch_pc<=RESET_PC, count/head/tail/inflight/drop<=0, and drive imem_req_valid=0 and if_valid=0.
REQ-029 SHALL, in the first cycle after reset deasserts, present imem_req_valid=1 with imem_req_addr=RESET_PC.
REQ-030 SHALL, on reset mid-operation, discard queued entries and any later responses to pre-reset requests are the environment's responsibility (instruction memory is reset on the same reset).

Verification
REQ-031 Reset then ready=1, one-cycle response latency, stall=0 -> addresses 0,4,8,... issued back to back; if_valid stream shows if_pc 0,4,8 with matching words.
REQ-032 stall held high with ready=1 -> exactly DEPTH (4) requests issued, then imem_req_valid=0; releasing stall for one cycle pops one entry and allows exactly one new request.
REQ-033 Two requests inflight (pc 8,12), redirect with redirect_pc=32'h100 -> next cycle if_valid=0, count=0, drop=2; both responses discarded; first delivered entry has if_pc=32'h100.
REQ-034 Redirect in the same cycle as a response and a pop -> response discarded, drop=inflight-1, nothing delivered that cycle, if_valid=0.
REQ-035 fetch_pc=32'hFFFFFFFC accepted -> next imem_req_addr=32'h00000000.
REQ-036 imem_req_ready=0 for 3 cycles -> imem_req_valid and imem_req_addr stable for all 3 cycles; fetch_pc advances only on the accepting cycle.

Source files
------------

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: credit-limited fetch requests, in-order response pairing,
// and redirect flushing with dropping of stale in-flight responses.
module prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   fetchPc;
  logic [31:0]   qPc    [DEPTH];
  logic [31:0]   qInstr [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;

  // Address of every outstanding request, oldest first, so responses can be paired.
  logic [31:0]   reqPc  [DEPTH];
  logic [PW-1:0] reqWr;
  logic [PW-1:0] reqRd;

  logic [CW:0]   occupancy;
  logic          creditOk;
  logic          reqFire;
  logic          push;
  logic          pop;

  assign occupancy      = {1'b0, count} + {1'b0, inflight};
  assign creditOk       = occupancy < (CW+1)'(DEPTH);
  assign imem_req_valid = !reset && !redirect && creditOk;
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign if_valid       = !reset && !redirect && (count != '0);
  assign if_instruction = qInstr[head];
  assign if_pc          = qPc[head];

  assign pop  = if_valid && !stall;
  assign push = !reset && !redirect && imem_resp_valid && (drop == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      reqWr    <= '0;
      reqRd    <= '0;
    end else begin
      if (reqFire) begin
        reqPc[reqWr] <= fetchPc;
        reqWr        <= reqWr + PW'(1);
      end
      if (imem_resp_valid)
        reqRd <= reqRd + PW'(1);

      if (redirect) begin
        // Everything still in flight belongs to the old path; this cycle's response is dropped directly.
        count    <= '0;
        head     <= tail;
        fetchPc  <= redirect_pc;
        drop     <= inflight - CW'(imem_resp_valid);
        inflight <= inflight - CW'(imem_resp_valid);
      end else begin
        if (reqFire)
          fetchPc <= fetchPc + 32'd4;
        inflight <= inflight + CW'(reqFire) - CW'(imem_resp_valid);
        if (imem_resp_valid && (drop != '0))
          drop <= drop - CW'(1);
        if (push) begin
          qPc[tail]    <= reqPc[reqRd];
          qInstr[tail] <= imem_resp_data;
          tail         <= tail + PW'(1);
        end
        if (pop)
          head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
